// File: rtl/imm_extend_if.sv
// Decode-stage immediate bus: instruction/select in, extended immediate out.
// The master drives the instruction side; the slave is the immediate generator.
interface imm_extend_if;
   logic [31:0] Instr;
   logic [2:0]  ImmSrc;
   logic        InValid;
   logic [31:0] ImmExt;
   logic        OutValid;
   logic        IllegalSrc;

   modport master (
      output Instr, ImmSrc, InValid,
      input  ImmExt, OutValid, IllegalSrc
   );

   modport slave (
      input  Instr, ImmSrc, InValid,
      output ImmExt, OutValid, IllegalSrc
   );
endinterface

// File: rtl/imm_extend.sv
// RV32I immediate generator: I/S/B/J/U formats sign- or upper-extended to 32 bits.
// The result is either registered (one-cycle latency) or passed straight through.
module imm_extend #(
   parameter bit REG_OUT = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   imm_extend_if.slave  bus
);

   logic [31:0] w_imm;
   logic        w_illegal;
   logic        w_unused_opcode;

   // Opcode bits never take part in the immediate.
   assign w_unused_opcode = ^bus.Instr[6:0];

   always_comb begin
      w_imm     = 32'h0000_0000;
      w_illegal = 1'b0;
      case (bus.ImmSrc)
         3'b000: w_imm = {{20{bus.Instr[31]}}, bus.Instr[31:20]};
         3'b001: w_imm = {{20{bus.Instr[31]}}, bus.Instr[31:25], bus.Instr[11:7]};
         3'b010: w_imm = {{20{bus.Instr[31]}}, bus.Instr[7], bus.Instr[30:25],
                          bus.Instr[11:8], 1'b0};
         3'b011: w_imm = {{12{bus.Instr[31]}}, bus.Instr[19:12], bus.Instr[20],
                          bus.Instr[30:21], 1'b0};
         3'b100: w_imm = {bus.Instr[31:12], 12'h000};
         // Reserved encodings and X both land here, so nothing can latch.
         default: begin
            w_imm     = 32'h0000_0000;
            w_illegal = 1'b1;
         end
      endcase
   end

   if (REG_OUT) begin : g_reg
      logic [31:0] r_imm;
      logic        r_valid;
      logic        r_illegal;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_imm     <= 32'h0000_0000;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
         end else begin
            r_imm     <= w_imm;
            r_valid   <= bus.InValid;
            r_illegal <= w_illegal;
         end
      end

      assign bus.ImmExt     = r_imm;
      assign bus.OutValid   = r_valid;
      assign bus.IllegalSrc = r_illegal;
   end else begin : g_comb
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst_n;

      assign bus.ImmExt     = w_imm;
      assign bus.OutValid   = bus.InValid;
      assign bus.IllegalSrc = w_illegal;
   end

endmodule

// File: tb/tb_imm_extend.sv
// Directed bench for imm_extend: registered and combinational instances driven
// with the same vectors, checked against hand-computed immediates.
module tb_imm_extend;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic        valid;
      logic [31:0] exp_imm;
      logic        exp_ill;
   } vec_t;

   localparam int N = 17;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   vec_t vecs[N];

   imm_extend_if bus_r ();
   imm_extend_if bus_c ();

   imm_extend #(.REG_OUT(1'b1)) u_dut_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_r)
   );

   imm_extend #(.REG_OUT(1'b0)) u_dut_comb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [2:0] src, input logic valid);
      bus_r.Instr   = instr;
      bus_r.ImmSrc  = src;
      bus_r.InValid = valid;
      bus_c.Instr   = instr;
      bus_c.ImmSrc  = src;
      bus_c.InValid = valid;
   endtask

   task automatic check_reg(input vec_t v, input string tag);
      chk({tag, " reg ImmExt"}, bus_r.ImmExt, v.exp_imm);
      chk({tag, " reg IllegalSrc"}, {31'b0, bus_r.IllegalSrc}, {31'b0, v.exp_ill});
      chk({tag, " reg OutValid"}, {31'b0, bus_r.OutValid}, {31'b0, v.valid});
   endtask

   task automatic check_comb(input vec_t v, input string tag);
      chk({tag, " comb ImmExt"}, bus_c.ImmExt, v.exp_imm);
      chk({tag, " comb IllegalSrc"}, {31'b0, bus_c.IllegalSrc}, {31'b0, v.exp_ill});
      chk({tag, " comb OutValid"}, {31'b0, bus_c.OutValid}, {31'b0, v.valid});
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " ImmExt"}, bus_r.ImmExt, 32'h0);
      chk({tag, " OutValid"}, {31'b0, bus_r.OutValid}, 32'h0);
      chk({tag, " IllegalSrc"}, {31'b0, bus_r.IllegalSrc}, 32'h0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      vecs[0]  = '{32'hFFC4A303, 3'b000, 1'b1, 32'hFFFFFFFC, 1'b0};
      vecs[1]  = '{32'h0064A423, 3'b001, 1'b1, 32'h00000008, 1'b0};
      vecs[2]  = '{32'hFE420AE3, 3'b010, 1'b1, 32'hFFFFFFF4, 1'b0};
      vecs[3]  = '{32'h0080006F, 3'b011, 1'b1, 32'h00000008, 1'b0};
      vecs[4]  = '{32'hF0F0F037, 3'b100, 1'b1, 32'hF0F0F000, 1'b0};
      vecs[5]  = '{32'h12345678, 3'b101, 1'b1, 32'h00000000, 1'b1};
      vecs[6]  = '{32'hFFFFFFFF, 3'b110, 1'b1, 32'h00000000, 1'b1};
      vecs[7]  = '{32'h0080006F, 3'b111, 1'b0, 32'h00000000, 1'b1};
      vecs[8]  = '{32'h7FF00013, 3'b000, 1'b1, 32'h000007FF, 1'b0};
      vecs[9]  = '{32'hFE112E23, 3'b001, 1'b0, 32'hFFFFFFFC, 1'b0};
      vecs[10] = '{32'hFFFFF06F, 3'b011, 1'b1, 32'hFFFFFFFE, 1'b0};
      vecs[11] = '{32'h00001037, 3'b100, 1'b1, 32'h00001000, 1'b0};
      vecs[12] = '{32'h0000007F, 3'b000, 1'b1, 32'h00000000, 1'b0};
      vecs[13] = '{32'h80000000, 3'b010, 1'b1, 32'hFFFFF000, 1'b0};
      vecs[14] = '{32'h80000000, 3'b001, 1'b1, 32'hFFFFF800, 1'b0};
      vecs[15] = '{32'h80000000, 3'b000, 1'b1, 32'hFFFFF800, 1'b0};
      vecs[16] = '{32'h80000000, 3'b011, 1'b1, 32'hFFF00000, 1'b0};

      // Reset held while inputs toggle: registered outputs stay clear.
      rst_n = 1'b0;
      drive(32'hFFC4A303, 3'b000, 1'b1);
      #1 check_zero("reset t0");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         drive(vecs[k + 1].instr, vecs[k + 1].src, 1'b1);
         #1 check_zero($sformatf("reset hold %0d", k));
      end

      @(negedge clk);
      drive(32'h0, 3'b000, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset idle OutValid", {31'b0, bus_r.OutValid}, 32'h0);

      // Back-to-back stream: each result one cycle after its input.
      for (int k = 0; k < N; k++) begin
         if (k > 0) check_reg(vecs[k - 1], $sformatf("vec%0d", k - 1));
         drive(vecs[k].instr, vecs[k].src, vecs[k].valid);
         #1 check_comb(vecs[k], $sformatf("vec%0d", k));
         @(negedge clk);
      end
      check_reg(vecs[N - 1], $sformatf("vec%0d", N - 1));

      // Mid-stream reset clears outputs without waiting for a clock edge.
      drive(vecs[0].instr, vecs[0].src, 1'b1);
      @(posedge clk);
      #2;
      check_reg(vecs[0], "pre-reset");
      rst_n = 1'b0;
      #1 check_zero("async reset");
      @(posedge clk);
      #1 check_zero("reset across edge");

      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[4].instr, vecs[4].src, 1'b1);
      @(negedge clk);
      check_reg(vecs[4], "after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_extend.md
Name: imm_extend

Overview:
- RV32I immediate generator for the single-cycle/pipelined RISC-V core's decode stage.
- Takes a 32-bit instruction word and a 3-bit immediate-format select.
- Produces the sign-extended (or upper-shifted) 32-bit immediate for the ALU/PC adder.
- Output is registered (one clock, asynchronous active-low reset) with a valid flag and an illegal-format flag.

Parameters:
- REG_OUT, 1: 1 = outputs registered (1-cycle latency); 0 = ImmExt/OutValid/IllegalSrc driven combinationally, clock and reset unused.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- Instr  input  32  instruction word
- ImmSrc  input  3  immediate format select
- InValid  input  1  Instr/ImmSrc valid this cycle
- ImmExt  output  32  extended immediate
- OutValid  output  1  ImmExt valid
- IllegalSrc  output  1  ImmSrc was an unsupported encoding

Behaviour:
- Format decode (i = Instr):
  - ImmSrc 000, I-type: {20{i[31]}, i[31:20]}
  - ImmSrc 001, S-type: {20{i[31]}, i[31:25], i[11:7]}
  - ImmSrc 010, B-type: {20{i[31]}, i[7], i[30:25], i[11:8], 1'b0}
  - ImmSrc 011, J-type: {12{i[31]}, i[19:12], i[20], i[30:21], 1'b0}
  - ImmSrc 100, U-type: {i[31:12], 12'b0}
  - ImmSrc 101/110/111: immediate = 32'h0000_0000; IllegalSrc = 1.
- Sign bit is always Instr[31]. Opcode bits [6:0] never affect the result; no opcode cross-check.
- Registered mode (REG_OUT=1):
  - On each rising clk, ImmExt, IllegalSrc and OutValid capture the decoded immediate, the illegal flag and InValid. Latency is exactly 1 cycle.
  - No stall/hold: a new value is sampled every cycle. When InValid=0, ImmExt/IllegalSrc still update, but OutValid=0 and consumers must ignore them.
  - IllegalSrc is asserted with the decoded value regardless of InValid; it is qualified by OutValid.
- Reset:
  - rst_n low immediately, without waiting for clk, forces ImmExt=0, OutValid=0, IllegalSrc=0.
  - Reset asserted mid-stream discards the in-flight value.
  - First capture occurs on the first rising clk after rst_n deasserts.
- Combinational mode (REG_OUT=0): OutValid=InValid; outputs follow inputs with zero latency; no state.
- X on ImmSrc must not latch; use a default branch yielding zero and IllegalSrc=1.

Test Plan:
- Reset: rst_n=0 with Instr/ImmSrc toggling -> ImmExt=0, OutValid=0, IllegalSrc=0 asynchronously. Release, then apply InValid=1 -> OutValid=1 one cycle later.
- I/S types:
  - ImmSrc=000, Instr=32'hFFC4A303 -> ImmExt=32'hFFFFFFFC after 1 clk.
  - ImmSrc=001, Instr=32'h0064A423 -> ImmExt=32'h00000008.
- B type: ImmSrc=010, Instr=32'hFE420AE3 -> ImmExt=32'hFFFFFFF4 (bit 0 forced 0).
- J/U types:
  - ImmSrc=011, Instr=32'h0080006F -> ImmExt=32'h00000008.
  - ImmSrc=100, Instr=32'hF0F0F037 -> ImmExt=32'hF0F0F000.
- Illegal select: ImmSrc=101/110/111, any Instr -> ImmExt=0, IllegalSrc=1. Next valid select -> IllegalSrc=0.
- Back-to-back and valid gating:
  - The five legal vectors on consecutive cycles -> each result appears exactly one cycle after its input, in order.
  - InValid=0 cycles -> OutValid=0 the following cycle.
  - Assert rst_n=0 mid-sequence -> outputs clear immediately.
